// File: rtl/set_assoc_tag_lru.sv
// set_assoc_tag_lru
//   Tag / valid / tree-PLRU store for one set-associative cache pipeline stage.
//   A lookup registers every way's tag and valid bit plus the PLRU victim one
//   cycle after the request. The following stage writes tags, invalidates sets
//   and promotes ways to MRU in the set it just looked up.
//
//   Optional build macro: TAG_LRU_BYPASS_EN
//     defined   - a lookup that coincides with a write / invalidate / LRU
//                 update to the same set registers the post-update values.
//     undefined - such a lookup registers the pre-update values.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   access_en/_set      lookup request and set
//   fill_en             lookup is a fill; a later update promotes fill_way
//   tag_we/_wr_*        per-way tag+valid write
//   inval_en/_set       clear all valid bits of a set
//   update_en/_way      promote a way in the last looked-up set
//   rd_tag/rd_valid     registered tags (way w at [w*TAG_WIDTH +: TAG_WIDTH])
//   fill_way            registered PLRU victim for the looked-up set
module set_assoc_tag_lru #(
    parameter int NUM_SETS  = 128,
    parameter int NUM_WAYS  = 4,
    parameter int TAG_WIDTH = 18,
    localparam int SW = $clog2(NUM_SETS),
    localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int LB = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          access_en,
    input  logic [SW-1:0]                 access_set,
    input  logic                          fill_en,
    input  logic [NUM_WAYS-1:0]           tag_we,
    input  logic [SW-1:0]                 tag_wr_set,
    input  logic [TAG_WIDTH-1:0]          tag_wr_tag,
    input  logic                          tag_wr_valid,
    input  logic                          inval_en,
    input  logic [SW-1:0]                 inval_set,
    input  logic                          update_en,
    input  logic [WW-1:0]                 update_way,
    output logic [NUM_WAYS*TAG_WIDTH-1:0] rd_tag,
    output logic [NUM_WAYS-1:0]           rd_valid,
    output logic [WW-1:0]                 fill_way
);

    // Walk from the root: a 0 bit sends the walk left (lower ways).
    function automatic logic [WW-1:0] plru_victim(input logic [LB-1:0] bits);
        logic [WW-1:0] v;
        int n;
        v = '0;
        n = 0;
        for (int l = 0; l < WW; l++) begin
            v[WW-1-l] = bits[n];
            n = 2 * n + 1 + int'(bits[n]);
        end
        return v;
    endfunction

    // Every node on the way's path is pointed at the other subtree.
    function automatic logic [LB-1:0] plru_promote(input logic [LB-1:0] bits,
                                                   input logic [WW-1:0] way);
        logic [LB-1:0] r;
        int n;
        r = bits;
        n = 0;
        for (int l = 0; l < WW; l++) begin
            r[n] = ~way[WW-1-l];
            n = 2 * n + 1 + int'(way[WW-1-l]);
        end
        return r;
    endfunction

    logic [TAG_WIDTH-1:0] tag_mem [NUM_WAYS][NUM_SETS];
    logic [NUM_SETS-1:0]  valid_q [NUM_WAYS];
    logic [SW-1:0]        lat_set;
    logic                 lat_fill;

    logic [TAG_WIDTH-1:0] lk_tag [NUM_WAYS];
    logic [NUM_WAYS-1:0]  lk_valid;
    logic [WW-1:0]        lk_victim;

    // Tag SRAMs are not reset.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WAYS; w++)
            if (tag_we[w]) tag_mem[w][tag_wr_set] <= tag_wr_tag;
    end

    // Invalidate is applied after the write so it wins on a set collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
        end else begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (tag_we[w]) valid_q[w][tag_wr_set] <= tag_wr_valid;
                if (inval_en)  valid_q[w][inval_set]  <= 1'b0;
            end
        end
    end

    always_comb begin
        lk_valid = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            lk_tag[w]   = tag_mem[w][access_set];
            lk_valid[w] = valid_q[w][access_set];
`ifdef TAG_LRU_BYPASS_EN
            if (tag_we[w] && tag_wr_set == access_set) begin
                lk_tag[w]   = tag_wr_tag;
                lk_valid[w] = tag_wr_valid;
            end
            if (inval_en && inval_set == access_set) lk_valid[w] = 1'b0;
`endif
        end
    end

    generate
        if (NUM_WAYS > 1) begin : g_lru
            logic [LB-1:0] lru_q [NUM_SETS];
            logic [LB-1:0] lk_lru;
            logic [LB-1:0] upd_lru;
            logic [WW-1:0] promote_way;

            // A fill lookup promotes the victim it handed out.
            assign promote_way = lat_fill ? fill_way : update_way;
            assign upd_lru     = plru_promote(lru_q[lat_set], promote_way);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < NUM_SETS; s++) lru_q[s] <= '0;
                end else if (update_en) begin
                    lru_q[lat_set] <= upd_lru;
                end
            end

            always_comb begin
                lk_lru = lru_q[access_set];
`ifdef TAG_LRU_BYPASS_EN
                if (update_en && lat_set == access_set) lk_lru = upd_lru;
`endif
            end

            assign lk_victim = plru_victim(lk_lru);
        end else begin : g_no_lru
            assign lk_victim = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_tag   <= '0;
            rd_valid <= '0;
            fill_way <= '0;
            lat_set  <= '0;
            lat_fill <= 1'b0;
        end else if (access_en) begin
            for (int w = 0; w < NUM_WAYS; w++)
                rd_tag[w*TAG_WIDTH +: TAG_WIDTH] <= lk_tag[w];
            rd_valid <= lk_valid;
            fill_way <= lk_victim;
            lat_set  <= access_set;
            lat_fill <= fill_en;
        end
    end

endmodule

// File: tb/tb_set_assoc_tag_lru.sv
module tb_set_assoc_tag_lru;

    localparam int NS = 128;
    localparam int NW = 4;
    localparam int TW = 18;

    logic            clk = 1'b0;
    logic            reset;
    logic            access_en, fill_en, tag_wr_valid, inval_en, update_en;
    logic [6:0]      access_set, tag_wr_set, inval_set;
    logic [NW-1:0]   tag_we;
    logic [TW-1:0]   tag_wr_tag;
    logic [1:0]      update_way;
    logic [NW*TW-1:0] rd_tag;
    logic [NW-1:0]   rd_valid;
    logic [1:0]      fill_way;

    set_assoc_tag_lru #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .access_en(access_en), .access_set(access_set), .fill_en(fill_en),
        .tag_we(tag_we), .tag_wr_set(tag_wr_set), .tag_wr_tag(tag_wr_tag),
        .tag_wr_valid(tag_wr_valid), .inval_en(inval_en), .inval_set(inval_set),
        .update_en(update_en), .update_way(update_way),
        .rd_tag(rd_tag), .rd_valid(rd_valid), .fill_way(fill_way)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NW-1:0]       valid;
        logic [NW-1:0]       known;
        logic [NW-1:0][TW-1:0] tag;
        logic [1:0]          fw;
    } exp_t;

    // reference model
    logic [TW-1:0] m_tag   [NW][NS];
    bit            m_known [NW][NS];
    bit            m_valid [NW][NS];
    logic [2:0]    m_lru   [NS];
    logic [6:0]    m_lat_set;
    bit            m_lat_fill;
    exp_t          last_exp;
    exp_t          sb[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_victim(input logic [2:0] b);
        if (!b[0]) return b[1] ? 2'd1 : 2'd0;
        else       return b[2] ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [2:0] m_promote(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        if (w < 2) begin r[0] = 1'b1; r[1] = (w == 2'd0); end
        else       begin r[0] = 1'b0; r[2] = (w == 2'd2); end
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_lru[s] = '0;
            for (int w = 0; w < NW; w++) begin
                m_valid[w][s] = 0;
                m_known[w][s] = 0;
            end
        end
        m_lat_set  = '0;
        m_lat_fill = 0;
        last_exp   = '0;
        last_exp.known = '1;
    endtask

    task automatic idle();
        access_en = 0; access_set = '0; fill_en = 0;
        tag_we = '0; tag_wr_set = '0; tag_wr_tag = '0; tag_wr_valid = 0;
        inval_en = 0; inval_set = '0; update_en = 0; update_way = '0;
    endtask

    task automatic cmp_out(input exp_t e, input string nm);
        check({nm, ".valid"}, 64'(rd_valid), 64'(e.valid));
        check({nm, ".fill_way"}, 64'(fill_way), 64'(e.fw));
        for (int w = 0; w < NW; w++)
            if (e.known[w])
                check({nm, ".tag"}, 64'(rd_tag[w*TW +: TW]), 64'(e.tag[w]));
    endtask

    // One clock: model computes from current inputs, then DUT is clocked and
    // the output is compared at the following falling edge.
    task automatic step(input string nm);
        exp_t e;
        logic [2:0] nl;
        logic [2:0] elru;
        logic [1:0] pw;
        bit acc;
        acc = access_en;
        e = last_exp;
        pw = m_lat_fill ? last_exp.fw : update_way;
        nl = m_promote(m_lru[m_lat_set], pw);
        if (acc) begin
            for (int w = 0; w < NW; w++) begin
                e.valid[w] = m_valid[w][access_set];
                e.known[w] = m_known[w][access_set];
                e.tag[w]   = m_tag[w][access_set];
`ifdef TAG_LRU_BYPASS_EN
                if (tag_we[w] && tag_wr_set == access_set) begin
                    e.valid[w] = tag_wr_valid; e.known[w] = 1; e.tag[w] = tag_wr_tag;
                end
                if (inval_en && inval_set == access_set) e.valid[w] = 0;
`endif
            end
            elru = m_lru[access_set];
`ifdef TAG_LRU_BYPASS_EN
            if (update_en && m_lat_set == access_set) elru = nl;
`endif
            e.fw = m_victim(elru);
            sb.push_back(e);
        end
        for (int w = 0; w < NW; w++) begin
            if (tag_we[w]) begin
                m_tag[w][tag_wr_set] = tag_wr_tag;
                m_known[w][tag_wr_set] = 1;
                m_valid[w][tag_wr_set] = tag_wr_valid;
            end
            if (inval_en) m_valid[w][inval_set] = 0;
        end
        if (update_en) m_lru[m_lat_set] = nl;
        if (acc) begin
            m_lat_set  = access_set;
            m_lat_fill = fill_en;
        end
        @(posedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            last_exp = sb.pop_front();
            cmp_out(last_exp, nm);
        end else begin
            cmp_out(last_exp, {nm, "_hold"});
        end
    endtask

    task automatic lookup(input logic [6:0] s, input bit fill, input string nm);
        idle();
        access_en = 1; access_set = s; fill_en = fill;
        step(nm);
    endtask

    task automatic update(input logic [1:0] w, input string nm);
        idle();
        update_en = 1; update_way = w;
        step(nm);
    endtask

    initial begin
        idle();
        reset = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(rd_valid), 64'h0);
        check("rst_fw", 64'(fill_way), 64'h0);
        check("rst_tag", rd_tag[63:0], 64'h0);
        reset = 1;
        @(negedge clk);

        lookup(7'd5, 0, "lk5");

        lookup(7'd3, 0, "lk3");
        update(2'd0, "upd0");
        lookup(7'd3, 0, "lk3_a");
        check("plru_w0", 64'(fill_way), 64'd2);
        update(2'd2, "upd2");
        lookup(7'd3, 0, "lk3_b");
        check("plru_w2", 64'(fill_way), 64'd1);

        idle(); tag_we = 4'b0010; tag_wr_set = 7'd7; tag_wr_tag = 18'h1ABC; tag_wr_valid = 1;
        step("wr7");
        lookup(7'd7, 0, "lk7");
        check("wr7_valid", 64'(rd_valid), 64'b0010);
        check("wr7_tag", 64'(rd_tag[TW +: TW]), 64'h1ABC);

        idle(); tag_we = 4'b0010; tag_wr_set = 7'd7; tag_wr_tag = 18'h2222; tag_wr_valid = 1;
        inval_en = 1; inval_set = 7'd7;
        step("wrinv7");
        lookup(7'd7, 0, "lk7_inv");
        check("inv_valid", 64'(rd_valid), 64'h0);
        check("inv_tag", 64'(rd_tag[TW +: TW]), 64'h2222);

        // same-cycle write + lookup (build-dependent result via model)
        idle(); tag_we = 4'b0001; tag_wr_set = 7'd9; tag_wr_tag = 18'h55; tag_wr_valid = 1;
        access_en = 1; access_set = 7'd9;
        step("rdw9");
        lookup(7'd9, 0, "lk9");
        check("wr9_tag", 64'(rd_tag[TW-1:0]), 64'h55);

        lookup(7'd11, 1, "fill11");
        update(2'd3, "upd_fill");
        lookup(7'd11, 0, "lk11");
        check("fill_promote", 64'(fill_way), 64'd2);

        // same-cycle update + lookup, and invalidate + lookup
        lookup(7'd12, 0, "lk12");
        idle(); update_en = 1; update_way = 2'd0; access_en = 1; access_set = 7'd12;
        step("rdu12");
        idle(); tag_we = 4'b1111; tag_wr_set = 7'd12; tag_wr_tag = 18'h3F00; tag_wr_valid = 1;
        step("wr12");
        idle(); inval_en = 1; inval_set = 7'd12; access_en = 1; access_set = 7'd12;
        step("rdi12");
        lookup(7'd12, 0, "lk12_b");

        // idle cycles: outputs hold
        idle(); step("idle");
        idle(); step("idle");

        // mid-operation reset discards the latched set and fill flag
        lookup(7'd20, 1, "fill20");
        idle();
        reset = 0;
        #1;
        check("mrst_valid", 64'(rd_valid), 64'h0);
        check("mrst_fw", 64'(fill_way), 64'h0);
        model_reset();
        @(negedge clk);
        reset = 1;
        update(2'd1, "upd_after_rst");
        lookup(7'd0, 0, "lk0_rst");
        check("mrst_set0", 64'(fill_way), 64'd2);

        // random traffic over a few sets
        for (int i = 0; i < 300; i++) begin
            idle();
            access_en = 1'($urandom_range(0, 1));
            access_set = 7'($urandom_range(0, 7));
            fill_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                tag_we = 4'($urandom);
                tag_wr_set = 7'($urandom_range(0, 7));
                tag_wr_tag = 18'($urandom);
                tag_wr_valid = 1'($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 5) == 0) begin
                inval_en = 1; inval_set = 7'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 0) begin
                update_en = 1; update_way = 2'($urandom);
            end
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
